// File: rtl/decode_fwd_stage_if.sv
// Fetch-side, forwarding and execute-side signals of the decode/operand-fetch stage.
// master = surrounding pipeline, slave = decode_fwd_stage.
interface decode_fwd_stage_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NFWD = 3,
  parameter int unsigned RW   = 5
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        in_pc;
  logic [31:0]            in_instr;
  logic                   in_use_rs1;
  logic                   in_use_rs2;
  logic [RW-1:0]          rs1;
  logic [RW-1:0]          rs2;
  logic [XLEN-1:0]        q1;
  logic [XLEN-1:0]        q2;
  logic [NFWD-1:0]        fwd_valid;
  logic [NFWD-1:0]        fwd_pending;
  logic [NFWD*RW-1:0]     fwd_dst;
  logic [NFWD*XLEN-1:0]   fwd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_pc;
  logic [31:0]            out_instr;
  logic [RW-1:0]          out_dst;
  logic [XLEN-1:0]        out_op1;
  logic [XLEN-1:0]        out_op2;

  modport master (
    output flush, in_valid, in_pc, in_instr, in_use_rs1, in_use_rs2,
           q1, q2, fwd_valid, fwd_pending, fwd_dst, fwd_data, out_ready,
    input  in_ready, rs1, rs2, out_valid, out_pc, out_instr, out_dst, out_op1, out_op2
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, in_use_rs1, in_use_rs2,
           q1, q2, fwd_valid, fwd_pending, fwd_dst, fwd_data, out_ready,
    output in_ready, rs1, rs2, out_valid, out_pc, out_instr, out_dst, out_op1, out_op2
  );
endinterface

// File: rtl/decode_fwd_stage.sv
// Decode/operand-fetch stage: regfile read, youngest-first forwarding, load-use interlock,
// valid/ready output with a 2-entry skid buffer. DECODE_PERF_EN adds saturating perf counters.
module decode_fwd_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NFWD = 3,
  parameter int unsigned RW   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  decode_fwd_stage_if.slave      bus
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]            perf_hazard_cycles,
  output logic [31:0]            perf_full_cycles,
  output logic [31:0]            perf_flushed
`endif
);

  logic [RW-1:0]   rs1_c;
  logic [RW-1:0]   rs2_c;
  logic [RW-1:0]   dst_c;
  logic [XLEN-1:0] op1_c;
  logic [XLEN-1:0] op2_c;
  logic            haz1_c;
  logic            haz2_c;
  logic            hazard_c;
  logic            in_ready_c;
  logic            accept_c;
  logic            load_main_c;
  logic            load_skid_c;

  logic            main_valid;
  logic [XLEN-1:0] main_pc;
  logic [31:0]     main_instr;
  logic [RW-1:0]   main_dst;
  logic [XLEN-1:0] main_op1;
  logic [XLEN-1:0] main_op2;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic [RW-1:0]   skid_dst;
  logic [XLEN-1:0] skid_op1;
  logic [XLEN-1:0] skid_op2;

  // Returns {hazard, operand}; the lowest-index matching source wins.
  function automatic logic [XLEN:0] resolve(input logic [RW-1:0]   idx,
                                            input logic [XLEN-1:0] q,
                                            input logic            use_f);
    logic [XLEN-1:0] op;
    logic            haz;
    logic            hit;
    op  = q;
    haz = 1'b0;
    hit = 1'b0;
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!hit && bus.fwd_valid[i] && (bus.fwd_dst[i*RW +: RW] == idx)) begin
        hit = 1'b1;
        if (bus.fwd_pending[i]) haz = use_f;
        else                    op  = bus.fwd_data[i*XLEN +: XLEN];
      end
    end
    if (idx == '0) begin
      op  = '0;
      haz = 1'b0;
    end
    return {haz, op};
  endfunction

  assign rs1_c = RW'(bus.in_instr[19:15]);
  assign rs2_c = RW'(bus.in_instr[24:20]);
  assign dst_c = RW'(bus.in_instr[11:7]);

  always_comb begin
    {haz1_c, op1_c} = resolve(rs1_c, bus.q1, bus.in_use_rs1);
    {haz2_c, op2_c} = resolve(rs2_c, bus.q2, bus.in_use_rs2);
  end

  // Flush forces ready so fetch can drop its offer; reset holds ready low.
  always_comb begin
    hazard_c    = bus.in_valid & (haz1_c | haz2_c);
    in_ready_c  = reset & (bus.flush | (~skid_valid & ~hazard_c));
    accept_c    = bus.in_valid & in_ready_c & ~bus.flush;
    load_main_c = ~bus.flush & (~main_valid | bus.out_ready) & (skid_valid | accept_c);
    load_skid_c = ~bus.flush & main_valid & ~bus.out_ready & accept_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || bus.out_ready) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept_c;
      end
    end else if (accept_c) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload registers only move on a transfer; stale data is kept while invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_pc    <= '0;
      main_instr <= '0;
      main_dst   <= '0;
      main_op1   <= '0;
      main_op2   <= '0;
    end else if (load_main_c) begin
      if (skid_valid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
        main_dst   <= skid_dst;
        main_op1   <= skid_op1;
        main_op2   <= skid_op2;
      end else begin
        main_pc    <= bus.in_pc;
        main_instr <= bus.in_instr;
        main_dst   <= dst_c;
        main_op1   <= op1_c;
        main_op2   <= op2_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_dst   <= '0;
      skid_op1   <= '0;
      skid_op2   <= '0;
    end else if (load_skid_c) begin
      skid_pc    <= bus.in_pc;
      skid_instr <= bus.in_instr;
      skid_dst   <= dst_c;
      skid_op1   <= op1_c;
      skid_op2   <= op2_c;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.rs1       = rs1_c;
  assign bus.rs2       = rs2_c;
  assign bus.out_valid = main_valid;
  assign bus.out_pc    = main_pc;
  assign bus.out_instr = main_instr;
  assign bus.out_dst   = main_dst;
  assign bus.out_op1   = main_op1;
  assign bus.out_op2   = main_op2;

`ifdef DECODE_PERF_EN
  localparam int unsigned CW = 32;

  logic [1:0]  kill_cnt_c;
  logic [CW:0] flushed_sum_c;

  always_comb begin
    kill_cnt_c    = bus.flush ? (2'(main_valid) + 2'(skid_valid)) : 2'd0;
    flushed_sum_c = {1'b0, perf_flushed} + (CW+1)'(kill_cnt_c);
  end

  // All three counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_hazard_cycles <= '0;
      perf_full_cycles   <= '0;
      perf_flushed       <= '0;
    end else begin
      if (hazard_c && (perf_hazard_cycles != '1))
        perf_hazard_cycles <= perf_hazard_cycles + CW'(1);
      if (skid_valid && (perf_full_cycles != '1))
        perf_full_cycles <= perf_full_cycles + CW'(1);
      perf_flushed <= flushed_sum_c[CW] ? '1 : flushed_sum_c[CW-1:0];
    end
  end
`endif

endmodule

// File: doc/decode_fwd_stage.md
Name: decode_fwd_stage

Overview:
- Parametrised decode/operand-fetch stage between fetch and execute.
- Reads register-file operands and resolves RAW hazards against NFWD forwarding sources, youngest first.
- Raises a load-use interlock when the matching source's data is still pending.
- Replaces the stall-signal interface with valid/ready handshakes and a 2-entry skid buffer, so in_ready never depends combinationally on out_ready.

Parameters:
XLEN, 64, datapath/operand width
NFWD, 3, number of forwarding sources; index 0 = youngest (highest priority)
RW, 5, register index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
flush  in  1  kill all held and incoming instructions (branch redirect)
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage accepts this cycle
in_pc  in  XLEN  instruction PC
in_instr  in  32  instruction word
in_use_rs1  in  1  instruction reads rs1 (from decoder)
in_use_rs2  in  1  instruction reads rs2
rs1  out  RW  regfile read index, = in_instr[19:15]
rs2  out  RW  regfile read index, = in_instr[24:20]
q1  in  XLEN  regfile data for rs1
q2  in  XLEN  regfile data for rs2
fwd_valid  in  NFWD  source i holds a register-writing instruction
fwd_pending  in  NFWD  source i result not yet available (load in flight)
fwd_dst  in  NFWD*RW  destination of source i
fwd_data  in  NFWD*XLEN  result of source i
out_valid  out  1  execute-side instruction valid
out_ready  in  1  execute accepts
out_pc  out  XLEN  PC
out_instr  out  32  instruction
out_dst  out  RW  in_instr[11:7]
out_op1  out  XLEN  resolved rs1 operand
out_op2  out  XLEN  resolved rs2 operand

Behaviour:
- Operand resolve (combinational, per operand):
  - Index 0 -> 0.
  - Otherwise take the lowest i with fwd_valid[i] && fwd_dst[i]==index.
  - Match with fwd_pending[i]=0 -> fwd_data[i]; match with fwd_pending[i]=1 -> hazard.
  - No match -> q1/q2.
  - An operand whose use flag is 0 never causes a hazard.
- hazard = in_valid & (haz1 | haz2).
- in_ready = !skid_valid & !hazard & reset-deasserted. During flush, in_ready = 1; the offered instruction is dropped.
- Storage: main register (drives out_*) and skid register. Each entry holds pc, instr, dst, op1, op2 and a valid bit.
- accept = in_valid & in_ready & !flush.
- Per-cycle update, main empty or out_ready:
  - If skid_valid: skid moves to main.
  - Else if accept: input goes to main.
  - Else: main valid clears.
- Per-cycle update, main full and !out_ready: accept goes to skid.
- Latency: accepted instruction appears on out_* the next cycle when the path is free.
- Order is preserved strictly. Operands are captured at accept time and never re-read.
- flush: main and skid valid clear next cycle. Flush has priority over accept and out_ready in the same cycle.
- Reset (reset=0, asynchronous):
  - out_valid=0 and skid_valid=0.
  - out_pc, out_instr, out_dst, out_op1, out_op2 = 0.
  - in_ready=0 while asserted.
  - Reset mid-transfer discards both entries.
- Full condition: skid_valid=1 -> in_ready=0.
- Data registers load only on a transfer. Invalid entries hold their last data.

Optional Feature:
DECODE_PERF_EN:
- Defined: adds outputs perf_hazard_cycles (32), perf_full_cycles (32) and perf_flushed (32).
  - perf_hazard_cycles increments each cycle hazard=1.
  - perf_full_cycles increments each cycle skid_valid=1.
  - perf_flushed increments by the number of valid entries killed by flush.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Forward priority: instr with rs1=5; fwd_valid=3'b110, dst[1]=dst[2]=5, data[1]=0x11, data[2]=0x22 -> out_op1=0x11 one cycle after accept.
- Load-use: rs2=7, source 0 dst=7, pending=1 for 2 cycles then 0 with data 0xAB -> in_ready=0 for 2 cycles; then accept with out_op2=0xAB.
- x0 and unused: rs1=0 with a source at dst=0 pending -> no hazard, op1=0. in_use_rs2=0 with a matching pending source -> no hazard.
- Backpressure: out_ready=0, three back-to-back valids A, B, C -> A in main, B in skid, in_ready=0 (C held). Then out_ready=1 -> A, B, C exit in order with no loss.
- Flush: main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, skid empty, offered instruction never appears.
- Async reset: reset=0 mid-cycle while out_valid=1 -> out_valid=0 immediately, before the next clock edge.
